// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the decoded register file.
// Imported by the interface, the write decoder and the register file top.
package reg_file_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam int ZERO_ADDR  = 0;

   // Number of entries addressed by an aw-bit address.
   function automatic int depth(input int aw);
      return 1 << aw;
   endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file_dec_if.sv
// Write and dual-read bus of the register file.
// The master drives addresses and write data; the slave returns read data and the decoded write vector.
interface reg_file_dec_if
   import reg_file_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic                       wr_en;
   logic [ADDR_W-1:0]          awr;
   logic [DATA_W-1:0]          din;
   logic [ADDR_W-1:0]          ard1;
   logic [ADDR_W-1:0]          ard2;
   logic [DATA_W-1:0]          dout1;
   logic [DATA_W-1:0]          dout2;
   logic [depth(ADDR_W)-1:0]   wr_one_hot;

   modport master (
      output wr_en, awr, din, ard1, ard2,
      input  dout1, dout2, wr_one_hot
   );

   modport slave (
      input  wr_en, awr, din, ard1, ard2,
      output dout1, dout2, wr_one_hot
   );

endinterface : reg_file_dec_if

// File: rtl/dec_n.sv
// Generic N-to-2^N one-hot decoder with enable.
// Output is all zeros when disabled, otherwise exactly bit sel is set.
module dec_n
   import reg_file_pkg::*;
#(
   parameter int N = ADDR_W_DEF
) (
   input  logic                en,
   input  logic [N-1:0]        sel,
   output logic [depth(N)-1:0] y
);

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      y = '0;
      if (en) y[sel] = 1'b1;
   end

endmodule : dec_n

// File: rtl/reg_file_dec.sv
// Two-read, one-write register file whose write port is driven by a one-hot decoder.
// Optional hard-wired zero entry, same-cycle write bypass and registered read data.
module reg_file_dec
   import reg_file_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   parameter bit REG_READ = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   reg_file_dec_if.slave  bus
);

   localparam int DEPTH = depth(ADDR_W);

   logic [DEPTH-1:0]  one_hot;
   logic [DEPTH-1:0]  wr_mask;
   logic [DATA_W-1:0] mem [DEPTH];

   dec_n #(.N(ADDR_W)) u_dec (
      .en  (bus.wr_en),
      .sel (bus.awr),
      .y   (one_hot)
   );

   assign bus.wr_one_hot = one_hot;

   // The decoded vector stays visible on the bus; only the storage enable drops entry 0.
   assign wr_mask = ZERO_REG ? {one_hot[DEPTH-1:1], 1'b0} : one_hot;

   // NOTE: the array is cleared by reset because every entry must read 0 after reset, so it maps to flops, not RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (wr_mask[k]) mem[k] <= bus.din;
         end
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] raw;
      logic [DATA_W-1:0] q;

      assign a = (p == 0) ? bus.ard1 : bus.ard2;

      // Zero entry has priority over bypass so a write to address 0 never leaks to a reader.
      always_comb begin
         raw = mem[a];
         if (BYPASS && bus.wr_en && (bus.awr == a)) raw = bus.din;
         if (ZERO_REG && (a == ADDR_W'(ZERO_ADDR))) raw = '0;
      end

      if (REG_READ) begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) q <= '0;
            else     q <= raw;
         end
      end else begin : g_comb
         assign q = raw;
      end
   end

   assign bus.dout1 = g_rd[0].q;
   assign bus.dout2 = g_rd[1].q;

endmodule : reg_file_dec

// File: tb/tb_reg_file_dec.sv
// Scoreboard bench for reg_file_dec: three configurations share one random stimulus stream
// and are checked against an array-based reference of the register file rules.
module tb_reg_file_dec;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NE = 32;
   localparam int NC = 3;

   // Config 0: zero reg + bypass, comb read. Config 1: plain comb read. Config 2: zero reg + bypass, registered read.
   function automatic bit cfg_zr(input int c);  return c != 1; endfunction
   function automatic bit cfg_byp(input int c); return c != 1; endfunction
   function automatic bit cfg_rr(input int c);  return c == 2; endfunction

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] awr = '0;
   logic [DW-1:0] din = '0;
   logic [AW-1:0] ard1 = '0;
   logic [AW-1:0] ard2 = '0;

   int cyc = 0;
   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   reg_file_dec_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   reg_file_dec_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   reg_file_dec_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

   assign bus0.wr_en = wr_en; assign bus0.awr = awr; assign bus0.din = din;
   assign bus0.ard1 = ard1;   assign bus0.ard2 = ard2;
   assign bus1.wr_en = wr_en; assign bus1.awr = awr; assign bus1.din = din;
   assign bus1.ard1 = ard1;   assign bus1.ard2 = ard2;
   assign bus2.wr_en = wr_en; assign bus2.awr = awr; assign bus2.din = din;
   assign bus2.ard1 = ard1;   assign bus2.ard2 = ard2;

   reg_file_dec #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_READ(1'b0))
      u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   reg_file_dec #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(1'b0), .BYPASS(1'b0), .REG_READ(1'b0))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   reg_file_dec #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_READ(1'b1))
      u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

   typedef struct {
      int                  cyc;
      logic [NC-1:0][DW-1:0] d1;
      logic [NC-1:0][DW-1:0] d2;
      logic [NE-1:0]       oh;
   } exp_t;

   exp_t sb[$];

   // Reference state: contents of each register file and last value captured by registered ports.
   logic [DW-1:0] mem_m [NC][NE];
   logic [DW-1:0] prev1 [NC];
   logic [DW-1:0] prev2 [NC];

   function automatic logic [DW-1:0] ref_read(input int c, input logic [AW-1:0] a);
      if (cfg_zr(c) && a == 0) return '0;
      if (cfg_byp(c) && wr_en && awr == a) return din;
      return mem_m[c][a];
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Apply one cycle of stimulus mid-cycle and queue what each configuration must show this cycle.
   task automatic step(input bit r, input bit we, input logic [AW-1:0] aw, input logic [DW-1:0] d,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      exp_t e;
      logic [DW-1:0] r1, r2;
      @(posedge clk);
      #1;
      rst = r; wr_en = we; awr = aw; din = d; ard1 = a1; ard2 = a2;
      if (r) begin
         for (int c = 0; c < NC; c++)
            for (int k = 0; k < NE; k++) mem_m[c][k] = '0;
      end
      e.cyc = cyc;
      e.oh  = we ? (NE'(1) << aw) : '0;
      for (int c = 0; c < NC; c++) begin
         r1 = ref_read(c, a1);
         r2 = ref_read(c, a2);
         if (cfg_rr(c)) begin
            e.d1[c] = r ? '0 : prev1[c];
            e.d2[c] = r ? '0 : prev2[c];
            prev1[c] = r ? '0 : r1;
            prev2[c] = r ? '0 : r2;
         end else begin
            e.d1[c] = r1;
            e.d2[c] = r2;
         end
         if (!r && we && !(cfg_zr(c) && aw == 0)) mem_m[c][aw] = d;
      end
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc != cyc) begin
            check("stale_entry", DW'(e.cyc), DW'(cyc));
         end else begin
            check("dout1_cfg0", bus0.dout1, e.d1[0]);
            check("dout2_cfg0", bus0.dout2, e.d2[0]);
            check("dout1_cfg1", bus1.dout1, e.d1[1]);
            check("dout2_cfg1", bus1.dout2, e.d2[1]);
            check("dout1_cfg2", bus2.dout1, e.d1[2]);
            check("dout2_cfg2", bus2.dout2, e.d2[2]);
            check("onehot_cfg0", bus0.wr_one_hot, e.oh);
            check("onehot_cfg1", bus1.wr_one_hot, e.oh);
            check("onehot_cfg2", bus2.wr_one_hot, e.oh);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [AW-1:0] aw, a1, a2;
      for (int c = 0; c < NC; c++) begin
         prev1[c] = '0;
         prev2[c] = '0;
         for (int k = 0; k < NE; k++) mem_m[c][k] = '0;
      end

      // Reset state, then fill a few entries and reset mid-cycle.
      step(1, 0, 0, 0, 0, 31);
      step(1, 0, 0, 0, 1, 31);
      step(0, 0, 0, 0, 1, 31);
      step(0, 1, 1, 32'h1111_1111, 0, 0);
      step(0, 1, 31, 32'h3131_3131, 0, 0);
      step(0, 1, 0, 32'h0F0F_0F0F, 1, 31);
      step(0, 0, 0, 0, 1, 31);
      step(1, 0, 0, 0, 1, 31);
      step(1, 0, 0, 0, 0, 1);
      step(1, 1, 5, 32'h0BAD_0BAD, 5, 0);
      step(0, 0, 0, 0, 5, 31);

      // Decode sweep.
      for (int i = 0; i < NE; i++) step(0, 1, AW'(i), $urandom, AW'(i), AW'(31 - i));
      step(0, 0, 0, 0, 0, 0);

      // Write then read.
      step(0, 1, 5, 32'hDEAD_BEEF, 0, 0);
      step(0, 1, 31, 32'h1234_5678, 5, 0);
      step(0, 0, 0, 0, 5, 31);
      step(0, 0, 0, 0, 5, 31);

      // Zero register.
      step(0, 1, 0, 32'hFFFF_FFFF, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Bypass against a freshly cleared entry.
      step(1, 0, 0, 0, 7, 7);
      step(0, 0, 0, 0, 7, 7);
      step(0, 1, 7, 32'hA5A5_A5A5, 7, 7);
      step(0, 0, 0, 0, 7, 7);

      // Registered read latency and asynchronous clear.
      step(0, 1, 3, 32'h0000_CAFE, 0, 0);
      step(0, 0, 0, 0, 3, 3);
      step(0, 0, 0, 0, 3, 3);
      step(1, 0, 0, 0, 3, 3);
      step(0, 0, 0, 0, 3, 3);

      // Back-to-back writes to one address.
      step(0, 1, 9, 32'h0000_0001, 9, 9);
      step(0, 1, 9, 32'h0000_0002, 9, 9);
      step(0, 0, 0, 0, 9, 9);

      // Random traffic with collisions and occasional reset.
      for (int i = 0; i < 400; i++) begin
         aw = AW'($urandom_range(0, NE - 1));
         a1 = ($urandom_range(0, 3) == 0) ? aw : AW'($urandom_range(0, NE - 1));
         a2 = ($urandom_range(0, 3) == 0) ? aw : AW'($urandom_range(0, NE - 1));
         if ($urandom_range(0, 7) == 0) a1 = 0;
         step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, aw, $urandom, a1, a2);
      end
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      check("sb_drain", DW'(sb.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_reg_file_dec
